cc_coef_commit_ctrl: RTL and testbench

//  Frame-synchronous coefficient commit controller for the colour-correction datapath.

---
 rtl/cc_coef_commit_ctrl_if.sv | 38 +++
 rtl/cc_coef_commit_ctrl.sv | 126 ++++++++++++
 tb/tb_cc_coef_commit_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cc_coef_commit_ctrl_if.sv
// ============================================================================
// cc_coef_commit_ctrl_if : CSR and video-stream signal bundle for the commit controller
// Revision 1.0
// ============================================================================
`default_nettype none

interface cc_coef_commit_ctrl_if #(
  parameter int COEF_WIDTH      = 16,
  parameter int FRAME_CNT_WIDTH = 16
);
  // Names carry the direction seen from the controller.
  logic [9*COEF_WIDTH-1:0]    cfg_coef_i;
  logic                       cfg_update_i;
  logic                       cfg_pending_o;
  logic [9*COEF_WIDTH-1:0]    active_coef_o;
  logic                       commit_o;
  logic                       video_tvalid_i;
  logic                       video_tuser_i;
  logic                       video_tready_o;
  logic                       video_tvalid_o;
  logic                       video_tready_i;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o;
  logic                       timeout_o;

  modport slave (
    input  cfg_coef_i, cfg_update_i, video_tvalid_i, video_tuser_i, video_tready_i,
    output cfg_pending_o, active_coef_o, commit_o, video_tready_o, video_tvalid_o,
           frame_cnt_o, timeout_o
  );

  modport master (
    output cfg_coef_i, cfg_update_i, video_tvalid_i, video_tuser_i, video_tready_i,
    input  cfg_pending_o, active_coef_o, commit_o, video_tready_o, video_tvalid_o,
           frame_cnt_o, timeout_o
  );
endinterface

`default_nettype wire

// File: rtl/cc_coef_commit_ctrl.sv
// ============================================================================
// cc_coef_commit_ctrl : frame-synchronous 3x3 coefficient commit (option CC_COMMIT_TIMEOUT_EN)
// Revision 1.0
// ============================================================================
`default_nettype none

module cc_coef_commit_ctrl #(
  parameter int COEF_WIDTH      = 16,
  parameter int FRACT_WIDTH     = 10,
  parameter int FRAME_CNT_WIDTH = 16
`ifdef CC_COMMIT_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1 << 22
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  cc_coef_commit_ctrl_if.slave  ctrl
);

  localparam logic [COEF_WIDTH-1:0] C_ONE  = {{(COEF_WIDTH-1){1'b0}}, 1'b1} << FRACT_WIDTH;
  localparam logic [COEF_WIDTH-1:0] C_ZERO = '0;
  localparam logic [9*COEF_WIDTH-1:0] C_IDENT =
    {C_ONE, C_ZERO, C_ZERO, C_ZERO, C_ONE, C_ZERO, C_ZERO, C_ZERO, C_ONE};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t                     state_q;
  logic [9*COEF_WIDTH-1:0]    shadow_q;
  logic [9*COEF_WIDTH-1:0]    active_q;
  logic                       commit_q;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;

  logic sof_pres;
  logic hold;
  logic tvalid_out;

  assign sof_pres   = ctrl.video_tvalid_i & ctrl.video_tuser_i;
  assign hold       = (state_q == ST_ARMED) & sof_pres;
  assign tvalid_out = ctrl.video_tvalid_i & ~hold;

`ifdef CC_COMMIT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             timeout_q;
  logic             tmo_hit;

  // A fresh update restarts the wait, so it also suppresses the forced commit.
  assign tmo_hit = (state_q == ST_ARMED) & (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))
                 & ~sof_pres & ~ctrl.cfg_update_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      shadow_q    <= C_IDENT;
      active_q    <= C_IDENT;
      commit_q    <= 1'b0;
      frame_cnt_q <= '0;
`ifdef CC_COMMIT_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      commit_q <= 1'b0;
      if (tvalid_out & ctrl.video_tready_i & ctrl.video_tuser_i) begin
        frame_cnt_q <= frame_cnt_q + FRAME_CNT_WIDTH'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (ctrl.cfg_update_i) begin
            shadow_q <= ctrl.cfg_coef_i;
            state_q  <= ST_ARMED;
`ifdef CC_COMMIT_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        ST_ARMED: begin
          if (ctrl.cfg_update_i) begin
            shadow_q <= ctrl.cfg_coef_i;
          end
`ifdef CC_COMMIT_TIMEOUT_EN
          if (ctrl.cfg_update_i) begin
            tmo_cnt_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
`endif
          if (sof_pres) begin
            // Same-cycle update bypasses the shadow so the newest write wins.
            active_q <= ctrl.cfg_update_i ? ctrl.cfg_coef_i : shadow_q;
            commit_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
`ifdef CC_COMMIT_TIMEOUT_EN
          else if (tmo_hit) begin
            active_q  <= shadow_q;
            commit_q  <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ctrl.cfg_pending_o  = (state_q == ST_ARMED);
  assign ctrl.active_coef_o  = active_q;
  assign ctrl.commit_o       = commit_q;
  assign ctrl.video_tvalid_o = tvalid_out;
  assign ctrl.video_tready_o = ctrl.video_tready_i & ~hold;
  assign ctrl.frame_cnt_o    = frame_cnt_q;
`ifdef CC_COMMIT_TIMEOUT_EN
  assign ctrl.timeout_o      = timeout_q;
`else
  assign ctrl.timeout_o      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cc_coef_commit_ctrl.sv
// ============================================================================
// tb_cc_coef_commit_ctrl : table-driven bench for the coefficient commit controller
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cc_coef_commit_ctrl;

  localparam int CW  = 16;
  localparam int FCW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cc_coef_commit_ctrl_if #(.COEF_WIDTH(CW), .FRAME_CNT_WIDTH(FCW)) bus ();

`ifdef CC_COMMIT_TIMEOUT_EN
  cc_coef_commit_ctrl #(.COEF_WIDTH(CW), .FRACT_WIDTH(10), .FRAME_CNT_WIDTH(FCW),
                        .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .rst_i(rst), .ctrl(bus)
  );
`else
  cc_coef_commit_ctrl #(.COEF_WIDTH(CW), .FRACT_WIDTH(10), .FRAME_CNT_WIDTH(FCW)) dut (
    .clk_i(clk), .rst_i(rst), .ctrl(bus)
  );
`endif

  typedef struct {
    int u, d, o, v, s, r;              // update, diag, off-diag seed, tvalid, tuser, tready
    int vo, ro, pe, co, ad, ao, fc;    // expected outputs
  } vec_t;

  vec_t tbl[28];
  int   n_pass = 0;
  int   n_total = 0;

  // Diagonal entries get d; off-diagonal k gets o+k (or 0 when o is 0).
  function automatic logic [9*CW-1:0] mat(input int d, input int o);
    logic [9*CW-1:0] m;
    for (int k = 0; k < 9; k++) begin
      if (k % 4 == 0) m[k*CW +: CW] = CW'(d);
      else            m[k*CW +: CW] = (o == 0) ? '0 : CW'(o + k);
    end
    return m;
  endfunction

  function automatic vec_t mk(input int u, d, o, v, s, r, vo, ro, pe, co, ad, ao, fc);
    vec_t t;
    t.u = u; t.d = d; t.o = o; t.v = v; t.s = s; t.r = r;
    t.vo = vo; t.ro = ro; t.pe = pe; t.co = co; t.ad = ad; t.ao = ao; t.fc = fc;
    return t;
  endfunction

  task automatic check(input string name, input int row, input logic [9*CW-1:0] act,
                       input logic [9*CW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
  endtask

  task automatic drive(input int u, d, o, v, s, r);
    bus.cfg_update_i   = u[0];
    bus.cfg_coef_i     = mat(d, o);
    bus.video_tvalid_i = v[0];
    bus.video_tuser_i  = s[0];
    bus.video_tready_i = r[0];
  endtask

  task automatic check_row(input int i, input vec_t t);
    check("tvalid_o", i, {{(9*CW-1){1'b0}}, bus.video_tvalid_o}, (9*CW)'(t.vo));
    check("tready_o", i, {{(9*CW-1){1'b0}}, bus.video_tready_o}, (9*CW)'(t.ro));
    check("pending",  i, {{(9*CW-1){1'b0}}, bus.cfg_pending_o},  (9*CW)'(t.pe));
    check("commit",   i, {{(9*CW-1){1'b0}}, bus.commit_o},       (9*CW)'(t.co));
    check("active",   i, bus.active_coef_o, mat(t.ad, t.ao));
    check("frame_cnt", i, {{(9*CW-FCW){1'b0}}, bus.frame_cnt_o}, (9*CW)'(t.fc));
    check("timeout",  i, {{(9*CW-1){1'b0}}, bus.timeout_o},      '0);
  endtask

  initial begin
    //             u  d      o     v  s  r   vo ro pe co ad     ao    fc
    tbl[0]  = mk(0, 0,     0,    1, 0, 1,  1, 1, 0, 0, 'h400, 0,    0);
    tbl[1]  = mk(0, 0,     0,    1, 1, 1,  1, 1, 0, 0, 'h400, 0,    0);
    tbl[2]  = mk(1, 'h200, 'h20, 1, 0, 1,  1, 1, 0, 0, 'h400, 0,    1);
    tbl[3]  = mk(0, 0,     0,    1, 0, 1,  1, 1, 1, 0, 'h400, 0,    1);
    tbl[4]  = mk(0, 0,     0,    1, 1, 1,  0, 0, 1, 0, 'h400, 0,    1);
    tbl[5]  = mk(0, 0,     0,    1, 1, 1,  1, 1, 0, 1, 'h200, 'h20, 1);
    tbl[6]  = mk(0, 0,     0,    0, 0, 1,  0, 1, 0, 0, 'h200, 'h20, 2);
    tbl[7]  = mk(1, 'h100, 'h30, 1, 0, 1,  1, 1, 0, 0, 'h200, 'h20, 2);
    tbl[8]  = mk(1, 'h300, 'h40, 0, 0, 1,  0, 1, 1, 0, 'h200, 'h20, 2);
    tbl[9]  = mk(0, 0,     0,    1, 1, 1,  0, 0, 1, 0, 'h200, 'h20, 2);
    tbl[10] = mk(0, 0,     0,    1, 1, 1,  1, 1, 0, 1, 'h300, 'h40, 2);
    tbl[11] = mk(0, 0,     0,    0, 0, 1,  0, 1, 0, 0, 'h300, 'h40, 3);
    tbl[12] = mk(1, 'h600, 'h50, 0, 0, 1,  0, 1, 0, 0, 'h300, 'h40, 3);
    tbl[13] = mk(1, 'h500, 'h60, 1, 1, 1,  0, 0, 1, 0, 'h300, 'h40, 3);
    tbl[14] = mk(0, 0,     0,    1, 1, 1,  1, 1, 0, 1, 'h500, 'h60, 3);
    tbl[15] = mk(0, 0,     0,    0, 0, 1,  0, 1, 0, 0, 'h500, 'h60, 4);
    tbl[16] = mk(1, 'h700, 'h70, 1, 1, 0,  1, 0, 0, 0, 'h500, 'h60, 4);
    tbl[17] = mk(0, 0,     0,    1, 1, 0,  0, 0, 1, 0, 'h500, 'h60, 4);
    tbl[18] = mk(0, 0,     0,    1, 1, 0,  1, 0, 0, 1, 'h700, 'h70, 4);
    tbl[19] = mk(0, 0,     0,    1, 1, 1,  1, 1, 0, 0, 'h700, 'h70, 4);
    tbl[20] = mk(0, 0,     0,    0, 0, 1,  0, 1, 0, 0, 'h700, 'h70, 5);
    tbl[21] = mk(1, 'h080, 'h08, 0, 0, 1,  0, 1, 0, 0, 'h700, 'h70, 5);
    tbl[22] = mk(0, 0,     0,    0, 0, 1,  0, 1, 1, 0, 'h700, 'h70, 5);
    tbl[23] = mk(0, 0,     0,    0, 0, 0,  0, 0, 1, 0, 'h700, 'h70, 5);
    tbl[24] = mk(0, 0,     0,    1, 0, 0,  1, 0, 1, 0, 'h700, 'h70, 5);
    tbl[25] = mk(0, 0,     0,    1, 1, 1,  0, 0, 1, 0, 'h700, 'h70, 5);
    tbl[26] = mk(0, 0,     0,    1, 1, 1,  1, 1, 0, 1, 'h080, 'h08, 5);
    tbl[27] = mk(0, 0,     0,    0, 0, 1,  0, 1, 0, 0, 'h080, 'h08, 6);

    drive(0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    check("rst_active",  -1, bus.active_coef_o, mat('h400, 0));
    check("rst_pending", -1, {{(9*CW-1){1'b0}}, bus.cfg_pending_o}, '0);
    check("rst_fcnt",    -1, {{(9*CW-FCW){1'b0}}, bus.frame_cnt_o}, '0);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].u, tbl[i].d, tbl[i].o, tbl[i].v, tbl[i].s, tbl[i].r);
      @(negedge clk);
      check_row(i, tbl[i]);
    end

    // Reset while armed drops the staged matrix; the next SOF passes unheld.
    @(posedge clk); #1; drive(1, 'h900, 'h90, 0, 0, 1);
    @(posedge clk); #1; drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("armed_before_rst", 100, {{(9*CW-1){1'b0}}, bus.cfg_pending_o}, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_pending2", 101, {{(9*CW-1){1'b0}}, bus.cfg_pending_o}, '0);
    check("rst_active2",  101, bus.active_coef_o, mat('h400, 0));
    check("rst_fcnt2",    101, {{(9*CW-FCW){1'b0}}, bus.frame_cnt_o}, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; drive(0, 0, 0, 1, 1, 1);
    @(negedge clk);
    check("post_rst_tvalid", 102, {{(9*CW-1){1'b0}}, bus.video_tvalid_o}, 1);
    check("post_rst_tready", 102, {{(9*CW-1){1'b0}}, bus.video_tready_o}, 1);
    @(posedge clk); #1; drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("post_rst_fcnt",   103, {{(9*CW-FCW){1'b0}}, bus.frame_cnt_o}, 1);
    check("post_rst_commit", 103, {{(9*CW-1){1'b0}}, bus.commit_o}, '0);
    check("post_rst_active", 103, bus.active_coef_o, mat('h400, 0));

`ifdef CC_COMMIT_TIMEOUT_EN
    // Forced commit after 64 armed cycles with no SOF; no beat is ever stalled.
    @(posedge clk); #1; drive(1, 'h0a0, 'h0a, 1, 0, 1);
    for (int j = 1; j <= 64; j++) begin
      @(posedge clk); #1; drive(0, 0, 0, 1, 0, 1);
      @(negedge clk);
      if (j == 1 || j == 64) begin
        check("tmo_pending", 200 + j, {{(9*CW-1){1'b0}}, bus.cfg_pending_o}, 1);
        check("tmo_tvalid",  200 + j, {{(9*CW-1){1'b0}}, bus.video_tvalid_o}, 1);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("tmo_commit",  300, {{(9*CW-1){1'b0}}, bus.commit_o}, 1);
    check("tmo_flag",    300, {{(9*CW-1){1'b0}}, bus.timeout_o}, 1);
    check("tmo_active",  300, bus.active_coef_o, mat('h0a0, 'h0a));
    check("tmo_pending", 300, {{(9*CW-1){1'b0}}, bus.cfg_pending_o}, '0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
